// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the pong game blocks.
//   state_t      : game sequencer state (2-bit, exposed as state_dbg)
//   DEF_*        : default raster / paddle geometry
//   COLOUR_*     : RGB888 colours shared with the renderers
//   bcd_inc()    : saturating packed-BCD increment, only built with SCORE_BCD_EN
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int DEF_HRES     = 1280;
  localparam int DEF_VRES     = 720;
  localparam int DEF_PADDLE_H = 20;

  localparam logic [23:0] COLOUR_BG     = 24'h000000;
  localparam logic [23:0] COLOUR_BALL   = 24'hFFFFFF;
  localparam logic [23:0] COLOUR_PADDLE = 24'h00FF00;
  localparam logic [23:0] COLOUR_OVER   = 24'hFF0000;

`ifdef SCORE_BCD_EN
  // Increments the low 'digits' BCD digits of v; a value of all 9s is returned unchanged.
  function automatic logic [31:0] bcd_inc(input logic [31:0] v, input int digits);
    logic [31:0] r;
    logic        carry;
    logic        all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < digits && v[4*i +: 4] != 4'd9) all9 = 1'b0;
    end
    if (!all9) begin
      for (int i = 0; i < 8; i++) begin
        if (i < digits && carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    bcd_inc = r;
  endfunction
`endif

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: raster/activity inputs and game-state outputs of the
// pong game sequencer.
//   fsync, vpos, active_obj, active_paddle : from the video side (master drives)
//   hold, game_over, score, lives, level, state_dbg : from the sequencer (slave drives)
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 12
);
  logic               fsync;
  logic signed [11:0] vpos;
  logic               active_obj;
  logic               active_paddle;
  logic               hold;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic [1:0]         level;
  logic [1:0]         state_dbg;

  modport master (
    output fsync, vpos, active_obj, active_paddle,
    input  hold, game_over, score, lives, level, state_dbg
  );

  modport slave (
    input  fsync, vpos, active_obj, active_paddle,
    output hold, game_over, score, lives, level, state_dbg
  );
endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// frame_timer: loadable frame down-counter.
//   pixel_clk, rst_n : clock, synchronous active-low reset (count <- RST_VAL)
//   load, load_val   : reload the count (takes priority over dec)
//   dec              : decrement by one, once per frame; holds at zero
//   done             : count has reached zero
module frame_timer #(
  parameter int W       = 7,
  parameter int RST_VAL = 0
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) count_q <= W'(RST_VAL);
    else        count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-level pong sequencer. Decides hit/miss once per frame,
// keeps score/lives/level and holds the ball and paddle during pauses.
//   pixel_clk, rst_n : clock, synchronous active-low reset
//   bus (slave)      : fsync/vpos/active_obj/active_paddle in;
//                      hold/game_over/score/lives/level/state_dbg out (all registered)
// Build option: SCORE_BCD_EN keeps score as packed BCD digits.
//
//   state | meaning
//   SERVE | ball held, waiting SERVE_FRAMES frames before release
//   PLAY  | ball live, paddle row watched for hit/miss each frame
//   MISS  | ball held for MISS_FRAMES frames after a lost life
//   OVER  | overlay on for OVER_FRAMES frames, then new game
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int VRES         = DEF_VRES,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int OVER_FRAMES  = 128,
  parameter int LEVEL_HITS   = 5,
  parameter int MAX_LEVEL    = 3,
  parameter int SCORE_W      = 12
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  pong_game_ctrl_if.slave  bus
);

  localparam int MAXF_A = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int MAXF   = (MAXF_A > OVER_FRAMES) ? MAXF_A : OVER_FRAMES;
  localparam int TW     = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int HW     = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;

  localparam logic signed [11:0] ROW    = 12'(VRES - PADDLE_H);
  localparam logic signed [11:0] VRES_S = 12'(VRES);
  localparam logic [2:0]         LIVES_V = 3'(LIVES);
  localparam logic [1:0]         MAXL_V  = 2'(MAX_LEVEL);

  state_t             state_q, state_d;
  logic               hold_q, hold_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [1:0]         level_q, level_d;
  logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
  logic               hit_seen_q, hit_seen_d;
  logic               obj_on_row_q, obj_on_row_d;
  logic               hit_prev_q, hit_prev_d;

  logic               on_row;
  logic               tmr_load;
  logic [TW-1:0]      tmr_load_val;
  logic               tmr_done;
  logic               score_inc;
`ifdef SCORE_BCD_EN
  logic [31:0]        bcd_next;
`endif

  // The range test keeps blanking lines out even if ROW were ever mis-set.
  assign on_row = (bus.vpos >= 12'sd0) && (bus.vpos < VRES_S) && (bus.vpos == ROW);

  frame_timer #(
    .W       (TW),
    .RST_VAL (SERVE_FRAMES - 1)
  ) u_frame_timer (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .dec       (bus.fsync),
    .done      (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    level_d      = level_q;
    hit_cnt_d    = hit_cnt_q;
    hit_seen_d   = hit_seen_q;
    obj_on_row_d = obj_on_row_q;
    hit_prev_d   = hit_prev_q;
    score_inc    = 1'b0;
`ifdef SCORE_BCD_EN
    bcd_next     = '0;
`endif

    if (bus.fsync) begin
      hit_seen_d   = 1'b0;
      obj_on_row_d = 1'b0;
      case (state_q)
        SERVE: if (tmr_done) state_d = PLAY;
        PLAY: begin
          hit_prev_d = hit_seen_q;
          if (hit_seen_q && !hit_prev_q) begin
`ifdef SCORE_BCD_EN
            bcd_next  = bcd_inc(32'(score_q), SCORE_W / 4);
            score_d   = bcd_next[SCORE_W-1:0];
            score_inc = (bcd_next[SCORE_W-1:0] != score_q);
`else
            if (score_q != '1) begin
              score_d   = score_q + SCORE_W'(1);
              score_inc = 1'b1;
            end
`endif
            // hit_cnt tracks score modulo LEVEL_HITS in binary, whatever the score format.
            if (score_inc) begin
              if (hit_cnt_q == HW'(LEVEL_HITS - 1)) begin
                hit_cnt_d = '0;
                if (level_q != MAXL_V) level_d = level_q + 2'd1;
              end else begin
                hit_cnt_d = hit_cnt_q + HW'(1);
              end
            end
          end else if (obj_on_row_q && !hit_seen_q) begin
            lives_d = lives_q - 3'd1;
            state_d = (lives_q == 3'd1) ? OVER : MISS;
          end
        end
        MISS: if (tmr_done) state_d = SERVE;
        OVER: begin
          if (tmr_done) begin
            score_d   = '0;
            lives_d   = LIVES_V;
            level_d   = 2'd0;
            hit_cnt_d = '0;
            state_d   = SERVE;
          end
        end
        default: state_d = SERVE;
      endcase
    end else if (state_q == PLAY && on_row) begin
      if (bus.active_obj)                      obj_on_row_d = 1'b1;
      if (bus.active_obj && bus.active_paddle) hit_seen_d   = 1'b1;
    end

    hold_d      = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = TW'(SERVE_FRAMES - 1);
    case (state_d)
      MISS:    tmr_load_val = TW'(MISS_FRAMES - 1);
      OVER:    tmr_load_val = TW'(OVER_FRAMES - 1);
      default: tmr_load_val = TW'(SERVE_FRAMES - 1);
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q      <= SERVE;
      hold_q       <= 1'b1;
      game_over_q  <= 1'b0;
      score_q      <= '0;
      lives_q      <= LIVES_V;
      level_q      <= 2'd0;
      hit_cnt_q    <= '0;
      hit_seen_q   <= 1'b0;
      obj_on_row_q <= 1'b0;
      hit_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      game_over_q  <= game_over_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      hit_cnt_q    <= hit_cnt_d;
      hit_seen_q   <= hit_seen_d;
      obj_on_row_q <= obj_on_row_d;
      hit_prev_q   <= hit_prev_d;
    end
  end

  assign bus.hold      = hold_q;
  assign bus.game_over = game_over_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.state_dbg = state_q;

endmodule
